// File: rtl/cv32e41s_ram_bridge_pkg.sv
// rtl/cv32e41s_ram_bridge_pkg.sv - shared types and byte-merge helper for the OBI RAM bridge
package cv32e41s_ram_bridge_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } bridge_state_e;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Byte i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic word_t be_merge(input word_t old_word, input word_t new_word,
                                     input logic [3:0] be);
    word_t merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cv32e41s_obi_ram_bridge.sv
// rtl/cv32e41s_obi_ram_bridge.sv - OBI subordinate to single RAM port, byte enables via read-modify-write
module cv32e41s_obi_ram_bridge
  import cv32e41s_ram_bridge_pkg::*;
#(
  parameter int A_WID    = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             obi_req_i,
  output logic             obi_gnt_o,
  input  logic [A_WID-1:0] obi_addr_i,
  input  logic             obi_we_i,
  input  logic [3:0]       obi_be_i,
  input  logic [31:0]      obi_wdata_i,
  output logic             obi_rvalid_o,
  output logic [31:0]      obi_rdata_o,
  output logic             obi_err_o,
  output logic             ram_en_o,
  output logic             ram_we_o,
  output logic [A_WID-1:0] ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i
);

  bridge_state_e    state_q;
  logic [A_WID-1:0] lat_addr_q;
  logic [3:0]       lat_be_q;
  word_t            lat_wdata_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rsp_read_q;

  logic [A_WID-1:0] word_addr;
  logic             out_of_range;
  logic             is_full_write;
  logic             is_partial_write;

  assign word_addr        = {obi_addr_i[A_WID-1:2], 2'b00};
  assign out_of_range     = (obi_addr_i >> 2) >= A_WID'(MEM_SIZE);
  assign is_full_write    = obi_we_i && (obi_be_i == BE_FULL);
  assign is_partial_write = obi_we_i && (obi_be_i != BE_FULL) && (obi_be_i != BE_NONE);

  // Grant and RAM port: driven from the live request in IDLE, from the latched request in RMW_WR;
  // everything is silenced while reset is asserted so an aborted RMW never reaches the RAM.
  always_comb begin
    obi_gnt_o   = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          obi_gnt_o = 1'b1;
          if (obi_req_i && !out_of_range) begin
            ram_addr_o = word_addr;
            if (!obi_we_i || is_partial_write) begin
              ram_en_o = 1'b1;
            end else if (is_full_write) begin
              ram_en_o    = 1'b1;
              ram_we_o    = 1'b1;
              ram_wdata_o = obi_wdata_i;
            end
          end
        end
        RMW_WR: begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = lat_addr_q;
          ram_wdata_o = be_merge(ram_rdata_i, lat_wdata_q, lat_be_q);
        end
        default: begin
          obi_gnt_o = 1'b0;
        end
      endcase
    end
  end

  // State register, latched partial-write request and one-deep response pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_addr_q  <= '0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (obi_req_i) begin
            if (out_of_range) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (is_partial_write) begin
              state_q     <= RMW_WR;
              lat_addr_q  <= word_addr;
              lat_be_q    <= obi_be_i;
              lat_wdata_q <= obi_wdata_i;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_read_q  <= !obi_we_i;
            end
          end
        end
        RMW_WR: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read data is taken straight from the RAM's output register during the response cycle.
  assign obi_rvalid_o = rsp_valid_q;
  assign obi_err_o    = rsp_err_q;
  assign obi_rdata_o  = (rsp_valid_q && rsp_read_q) ? ram_rdata_i : 32'h0;

endmodule
